// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single-ported unified
// memory. Requester 0 is instruction fetch, requester 1 is data load/store.
// A winner owns the port for MemLatency cycles, the read word is captured on
// the last access cycle and handed back with a one-cycle Done pulse.
module mem_port_arbiter #(
    parameter int MemLatency = 2,
    parameter int NBits      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [NBits-1:0] Mem_ReadData,
    output logic             Arb_Selector,
    output logic             Mem_Enable,
    output logic             Grant0,
    output logic             Grant1,
    output logic             Done0,
    output logic             Done1,
    output logic [NBits-1:0] Arb_ReadData
);

    localparam int CntW = (MemLatency > 1) ? $clog2(MemLatency) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MemLatency - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t          state;
    logic [CntW-1:0] lat_cnt;
    logic            last_grant;
    logic            winner;
    logic            next_winner;

    // Pick the requester that would win if the port were granted now:
    // a lone request wins outright, a tie goes to whoever did not win last.
    always_comb begin
        next_winner = Req1;
        if (Req0 && Req1) begin
            next_winner = ~last_grant;
        end
    end

    // Sequencer: grant in IDLE, time the access, then pulse Done for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            last_grant   <= 1'b1;
            winner       <= 1'b0;
            Arb_Selector <= 1'b0;
            Mem_Enable   <= 1'b0;
            Grant0       <= 1'b0;
            Grant1       <= 1'b0;
            Done0        <= 1'b0;
            Done1        <= 1'b0;
            Arb_ReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done0 <= 1'b0;
                    Done1 <= 1'b0;
                    if (Req0 || Req1) begin
                        winner       <= next_winner;
                        Arb_Selector <= next_winner;
                        Grant0       <= ~next_winner;
                        Grant1       <= next_winner;
                        Mem_Enable   <= 1'b1;
                        lat_cnt      <= CntLoad;
                        state        <= ACCESS;
                    end else begin
                        Grant0     <= 1'b0;
                        Grant1     <= 1'b0;
                        Mem_Enable <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        // Last access cycle: the memory word is valid now.
                        Arb_ReadData <= Mem_ReadData;
                        last_grant   <= winner;
                        Done0        <= ~winner;
                        Done1        <= winner;
                        Grant0       <= 1'b0;
                        Grant1       <= 1'b0;
                        Mem_Enable   <= 1'b0;
                        state        <= COMPLETE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                COMPLETE: begin
                    // Requests are deliberately ignored here so a requester
                    // has one cycle to drop Req after seeing Done.
                    Done0 <= 1'b0;
                    Done1 <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    Grant0     <= 1'b0;
                    Grant1     <= 1'b0;
                    Mem_Enable <= 1'b0;
                    Done0      <= 1'b0;
                    Done1      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MemLatency 1, 2, 3) share the
// same stimulus and are compared every cycle against a transaction-timing
// reference model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        Req0;
    logic        Req1;
    logic [31:0] Mem_ReadData;

    logic        sel_o [3];
    logic        en_o  [3];
    logic        g0_o  [3];
    logic        g1_o  [3];
    logic        d0_o  [3];
    logic        d1_o  [3];
    logic [31:0] rd_o  [3];

    int checks   = 0;
    int failures = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mem_port_arbiter #(
            .MemLatency(k + 1),
            .NBits     (32)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .Req0        (Req0),
            .Req1        (Req1),
            .Mem_ReadData(Mem_ReadData),
            .Arb_Selector(sel_o[k]),
            .Mem_Enable  (en_o[k]),
            .Grant0      (g0_o[k]),
            .Grant1      (g1_o[k]),
            .Done0       (d0_o[k]),
            .Done1       (d1_o[k]),
            .Arb_ReadData(rd_o[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper: every check in the bench goes through here.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transaction starts at the edge it is sampled (s);
    // relative to that edge the port is owned for offsets 0..L-1, Done shows at
    // offset L, offset L+1 is the dead COMPLETE cycle, sampling resumes at L+2.
    int          edge_n = 0;
    bit          m_busy [3];
    int          m_s    [3];
    bit          m_w    [3];
    bit          m_last [3];
    bit          m_sel  [3];
    bit          m_en   [3];
    bit          m_g0   [3];
    bit          m_g1   [3];
    bit          m_d0   [3];
    bit          m_d1   [3];
    logic [31:0] m_rd   [3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int lat;
            int d;
            lat = k + 1;
            m_en[k] = 0; m_g0[k] = 0; m_g1[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
            if (reset) begin
                m_busy[k] = 0;
                m_sel[k]  = 0;
                m_last[k] = 1;
                m_rd[k]   = '0;
            end else begin
                if (m_busy[k] && (edge_n - m_s[k]) > lat + 1) m_busy[k] = 0;
                if (!m_busy[k] && (Req0 || Req1)) begin
                    m_busy[k] = 1;
                    m_s[k]    = edge_n;
                    m_w[k]    = (Req0 && Req1) ? !m_last[k] : Req1;
                end
                if (m_busy[k]) begin
                    d = edge_n - m_s[k];
                    if (d < lat) begin
                        m_en[k]  = 1;
                        m_sel[k] = m_w[k];
                        m_g0[k]  = !m_w[k];
                        m_g1[k]  = m_w[k];
                    end else if (d == lat) begin
                        m_d0[k]   = !m_w[k];
                        m_d1[k]   = m_w[k];
                        m_rd[k]   = Mem_ReadData;
                        m_last[k] = m_w[k];
                    end
                end
            end
        end
        edge_n++;
    endtask

    // One clock: model follows the edge, DUT outputs are compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("outs_L%0d", k + 1),
                64'({sel_o[k], en_o[k], g0_o[k], g1_o[k], d0_o[k], d1_o[k], rd_o[k]}),
                64'({m_sel[k], m_en[k], m_g0[k], m_g1[k], m_d0[k], m_d1[k], m_rd[k]}));
            chk($sformatf("en_is_grant_L%0d", k + 1), 64'(en_o[k]), 64'(g0_o[k] | g1_o[k]));
            chk($sformatf("grant_excl_L%0d", k + 1), 64'(g0_o[k] & g1_o[k]), 64'd0);
            chk($sformatf("done_excl_L%0d", k + 1), 64'(d0_o[k] & d1_o[k]), 64'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        Req0         = 1'b1;
        Req1         = 1'b1;
        Mem_ReadData = 32'h0;

        // Reset with both requests high, then a long tie run (alternation).
        repeat (3) cycle();
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            Mem_ReadData = $urandom;
            cycle();
        end

        // Lone Req1 dropped right after being sampled; constant read word.
        reset = 1'b1;
        Req0  = 1'b0;
        Req1  = 1'b0;
        cycle();
        reset        = 1'b0;
        Mem_ReadData = 32'hDEADBEEF;
        Req1         = 1'b1;
        cycle();
        Req1 = 1'b0;
        repeat (8) cycle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("deadbeef_L%0d", k + 1), 64'(rd_o[k]), 64'h00000000DEADBEEF);
        end

        // Randomised traffic with occasional resets landing mid-access.
        for (int i = 0; i < 1500; i++) begin
            Req0         = ($urandom_range(0, 3) != 0);
            Req1         = ($urandom_range(0, 2) != 0);
            Mem_ReadData = $urandom;
            reset        = ($urandom_range(0, 60) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-ported unified memory of the MIPS core.
- Requester 0 is instruction fetch; requester 1 is data load/store.
- Arb_Selector drives the Selector input of the address/write-data 2-to-1 multiplexer in front of the memory.
- The block times a fixed-latency memory access and returns the read word to the winning requester.

Parameters:
- MemLatency, 2: memory cycles from Mem_Enable assertion to valid Mem_ReadData; legal range >=1.
- NBits, 32: data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Req0  input  1  instruction-fetch request; level, held until Done0.
- Req1  input  1  data request; level, held until Done1.
- Mem_ReadData  input  NBits  memory read word.
- Arb_Selector  output  1  multiplexer select: 0 = requester 0 address, 1 = requester 1 address.
- Mem_Enable  output  1  memory access strobe.
- Grant0  output  1  requester 0 owns the memory port.
- Grant1  output  1  requester 1 owns the memory port.
- Done0  output  1  one-cycle completion pulse for requester 0.
- Done1  output  1  one-cycle completion pulse for requester 1.
- Arb_ReadData  output  NBits  captured read word; valid in the Done cycle and held until the next capture.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, Arb_Selector=0, Mem_Enable=0, Grant0/1=0, Done0/1=0, Arb_ReadData=0, LastGrant=1, latency counter=0.
- Reset asserted mid-access aborts the access. All of the above take effect at the next edge, and no Done pulse is issued.
- States:
  - IDLE.
  - ACCESS: lasts MemLatency cycles.
  - COMPLETE: lasts 1 cycle.
- IDLE, no request: remain in IDLE; all outputs 0. Arb_Selector holds its last value.
- IDLE, Req0 xor Req1: winner = the requester that is asserting.
- IDLE, Req0 and Req1 both high: winner = ~LastGrant. Because LastGrant resets to 1, requester 0 wins the first tie.
- IDLE, on a request (edge at end of cycle T):
  - Next state ACCESS.
  - Arb_Selector=winner; Grant[winner]=1; Mem_Enable=1.
  - Counter=MemLatency-1.
- ACCESS:
  - Grant, Mem_Enable and Arb_Selector are held stable.
  - Counter decrements each cycle.
  - When counter==0: capture Mem_ReadData into Arb_ReadData; LastGrant=winner; next state COMPLETE.
- COMPLETE:
  - Done[winner]=1; Grant0/1=0; Mem_Enable=0.
  - Next state IDLE unconditionally. Requests are not sampled in this cycle.
- Timing: request sampled at edge T gives Grant/Mem_Enable high during cycles T+1..T+MemLatency and Done high in cycle T+MemLatency+1. Earliest next grant is in cycle T+MemLatency+3.
- Requester contract: Req must be deasserted no later than the cycle after its Done pulse. A Req still high in IDLE is treated as a new request.
- Req dropped during ACCESS: the access still completes and Done still pulses.
- Continuous Req0 and Req1: grants alternate strictly, 0,1,0,1,...
- Counter width: ceil(log2(MemLatency)) bits, minimum 1.
- MemLatency=1: a single ACCESS cycle.
- Invariants:
  - Grant0 and Grant1 are never high together.
  - Done0 and Done1 are never high together.
  - Mem_Enable = Grant0 | Grant1.

Test Plan:
- Reset with Req0=Req1=1 → while reset is high and one cycle after its release, all outputs 0. The first grant goes to requester 0 (Arb_Selector=0).
- MemLatency=2, Req1 alone sampled at edge 0, Mem_ReadData=32'hDEADBEEF in cycle 2 → Grant1=Mem_Enable=1 and Arb_Selector=1 in cycles 1-2; Done1=1 and Arb_ReadData=32'hDEADBEEF in cycle 3; IDLE in cycle 4.
- Req0 and Req1 held high for 4 transactions, each requester dropping and re-raising Req after its Done → grant order 0,1,0,1; Grant0 and Grant1 never overlap; each Done pulse is exactly 1 cycle.
- MemLatency=1, Req0 with Mem_ReadData=32'h00000005 → Grant0 in cycle 1 only; Done0 and Arb_ReadData=5 in cycle 2.
- Reset asserted in the second ACCESS cycle of a requester-0 transaction (MemLatency=3) → next cycle all outputs 0 and no Done0 pulse; a subsequent tie is won by requester 0.
- Req1 dropped in the first ACCESS cycle → Done1 still pulses at T+MemLatency+1; Arb_ReadData is updated.
